// File: rtl/mips_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_if_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        HOLD    = 2'b01,
        DISCARD = 2'b10
    } if_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES = 32'd4;

endpackage

// File: rtl/ifetch_hold_buf.sv
// One-entry {PC+4, instruction} buffer holding a fetched word while decode is stalled.
module ifetch_hold_buf
    import mips_if_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     load,
    input  logic                     clear,
    input  logic [ADDRESS_WIDTH-1:0] d_pc,
    input  logic [DATA_WIDTH-1:0]    d_instr,
    output logic [ADDRESS_WIDTH-1:0] q_pc,
    output logic [DATA_WIDTH-1:0]    q_instr,
    output logic                     q_valid
);

    logic [ADDRESS_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0]    instr_r;
    logic                     valid_r;

    // Buffer storage; clear wins over load.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            pc_r    <= {ADDRESS_WIDTH{1'b0}};
            instr_r <= DATA_WIDTH'(NOP_INSTR);
            valid_r <= 1'b0;
        end else if (clear) begin
            pc_r    <= {ADDRESS_WIDTH{1'b0}};
            instr_r <= DATA_WIDTH'(NOP_INSTR);
            valid_r <= 1'b0;
        end else if (load) begin
            pc_r    <= d_pc;
            instr_r <= d_instr;
            valid_r <= 1'b1;
        end else begin
            pc_r    <= pc_r;
            instr_r <= instr_r;
            valid_r <= valid_r;
        end
    end

    assign q_pc    = pc_r;
    assign q_instr = instr_r;
    assign q_valid = valid_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC ownership, imem request handshake, redirect and stall handling.
// Optional macro IFETCH_MISALIGN_TRAP_EN traps misaligned redirect targets to EXC_VECTOR.
module instr_fetch
    import mips_if_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0] EXC_VECTOR    = 32'h0000_0180
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Stall,
    input  logic                     i_Redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_Redirect_Target,
    output logic [ADDRESS_WIDTH-1:0] o_IMem_Addr,
    output logic                     o_IMem_Req,
    input  logic                     i_IMem_Ack,
    input  logic [DATA_WIDTH-1:0]    i_IMem_Data,
    output logic [ADDRESS_WIDTH-1:0] o_PC,
    output logic [DATA_WIDTH-1:0]    o_Instruction,
    output logic                     o_Valid,
    output logic                     o_Misaligned
);

    if_state_e                state_r, state_nxt_s;
    logic [ADDRESS_WIDTH-1:0] pc_r, pc_nxt_s, pc_plus4_s;
    logic [ADDRESS_WIDTH-1:0] stale_addr_r, stale_nxt_s;
    logic [ADDRESS_WIDTH-1:0] target_s;
    logic                     misaligned_s;
    logic                     buf_load_s, buf_clear_s;
    logic [ADDRESS_WIDTH-1:0] buf_pc_s;
    logic [DATA_WIDTH-1:0]    buf_instr_s;
    logic                     buf_valid_s;

    assign pc_plus4_s = pc_r + ADDRESS_WIDTH'(INSTR_BYTES);

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign misaligned_s = |i_Redirect_Target[1:0];
    assign target_s     = misaligned_s ? EXC_VECTOR : i_Redirect_Target;
`else
    assign misaligned_s = 1'b0;
    assign target_s     = i_Redirect_Target & ~{{(ADDRESS_WIDTH-2){1'b0}}, 2'b11};
`endif

    ifetch_hold_buf #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_hold_buf (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .load      (buf_load_s),
        .clear     (buf_clear_s),
        .d_pc      (pc_plus4_s),
        .d_instr   (i_IMem_Data),
        .q_pc      (buf_pc_s),
        .q_instr   (buf_instr_s),
        .q_valid   (buf_valid_s)
    );

    // State, PC and the address of a request that is being abandoned.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_r      <= FETCH;
            pc_r         <= RESET_VECTOR;
            stale_addr_r <= RESET_VECTOR;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            stale_addr_r <= stale_nxt_s;
        end
    end

    // Next-state, PC update and presented outputs.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        stale_nxt_s   = stale_addr_r;
        buf_load_s    = 1'b0;
        buf_clear_s   = 1'b0;
        o_IMem_Req    = 1'b1;
        o_IMem_Addr   = pc_r;
        o_Valid       = 1'b0;
        o_PC          = {ADDRESS_WIDTH{1'b0}};
        o_Instruction = DATA_WIDTH'(NOP_INSTR);
        o_Misaligned  = 1'b0;

        // Redirect overrides stall and ack; only an unacked live request forces DISCARD.
        if (i_Redirect) begin
            pc_nxt_s     = target_s;
            buf_clear_s  = 1'b1;
            o_Misaligned = misaligned_s;
        end else begin
            o_Misaligned = 1'b0;
        end

        case (state_r)
            FETCH: begin
                stale_nxt_s = pc_r;
                if (i_Redirect) begin
                    state_nxt_s = i_IMem_Ack ? FETCH : DISCARD;
                end else if (i_IMem_Ack) begin
                    o_Valid       = 1'b1;
                    o_PC          = pc_plus4_s;
                    o_Instruction = i_IMem_Data;
                    if (i_Stall) begin
                        buf_load_s  = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        pc_nxt_s = pc_plus4_s;
                    end
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            HOLD: begin
                o_IMem_Req = 1'b0;
                if (i_Redirect) begin
                    state_nxt_s = FETCH;
                end else begin
                    o_Valid       = buf_valid_s;
                    o_PC          = buf_pc_s;
                    o_Instruction = buf_instr_s;
                    if (!i_Stall) begin
                        pc_nxt_s    = pc_plus4_s;
                        buf_clear_s = 1'b1;
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
            end
            DISCARD: begin
                o_IMem_Addr = stale_addr_r;
                if (i_IMem_Ack) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = DISCARD;
                end
            end
            default: begin
                state_nxt_s = FETCH;
                buf_clear_s = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a transaction-level reference model.
module tb_instr_fetch;

    logic        i_Clk;
    logic        i_Reset_n;
    logic        i_Stall;
    logic        i_Redirect;
    logic [31:0] i_Redirect_Target;
    logic [31:0] o_IMem_Addr;
    logic        o_IMem_Req;
    logic        i_IMem_Ack;
    logic [31:0] i_IMem_Data;
    logic [31:0] o_PC;
    logic [31:0] o_Instruction;
    logic        o_Valid;
    logic        o_Misaligned;

    int tests_run;
    int tests_failed;

    // Reference model: architectural PC, optional held word, optional abandoned request.
    logic [31:0] m_pc;
    bit          m_held;
    logic [31:0] m_hpc;
    logic [31:0] m_hinstr;
    bit          m_drop;
    logic [31:0] m_daddr;

    instr_fetch dut (
        .i_Clk             (i_Clk),
        .i_Reset_n         (i_Reset_n),
        .i_Stall           (i_Stall),
        .i_Redirect        (i_Redirect),
        .i_Redirect_Target (i_Redirect_Target),
        .o_IMem_Addr       (o_IMem_Addr),
        .o_IMem_Req        (o_IMem_Req),
        .i_IMem_Ack        (i_IMem_Ack),
        .i_IMem_Data       (i_IMem_Data),
        .o_PC              (o_PC),
        .o_Instruction     (o_Instruction),
        .o_Valid           (o_Valid),
        .o_Misaligned      (o_Misaligned)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_held = 1'b0; m_hpc = 32'h0; m_hinstr = 32'h0;
        m_drop = 1'b0; m_daddr = 32'h0;
    endtask

    task automatic do_reset();
        i_Reset_n = 1'b0; i_Stall = 1'b0; i_Redirect = 1'b0;
        i_Redirect_Target = 32'h0; i_IMem_Ack = 1'b0; i_IMem_Data = 32'h0;
        #3;
        chk("rst_valid", {31'h0, o_Valid}, 32'h0);
        chk("rst_pc", o_PC, 32'h0);
        chk("rst_instr", o_Instruction, 32'h0);
        chk("rst_misal", {31'h0, o_Misaligned}, 32'h0);
        @(posedge i_Clk); #1;
        i_Reset_n = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus; optionally also checks the fetch address against a constant.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] tgt, input bit ak,
                         input bit kchk, input logic [31:0] kaddr);
        logic        e_req, e_valid, e_mis;
        logic [31:0] e_addr, e_pc, e_instr, tgt_eff;
        e_req  = !m_held;
        e_addr = m_drop ? m_daddr : m_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
        e_mis   = rd && (tgt % 4 != 0);
        tgt_eff = (tgt % 4 != 0) ? 32'h0000_0180 : tgt;
`else
        e_mis   = 1'b0;
        tgt_eff = tgt - (tgt % 4);
`endif
        e_valid = 1'b0; e_pc = 32'h0; e_instr = 32'h0;
        if (!rd && m_held) begin
            e_valid = 1'b1; e_pc = m_hpc; e_instr = m_hinstr;
        end else if (!rd && !m_drop && ak) begin
            e_valid = 1'b1; e_pc = m_pc + 32'd4; e_instr = mem_word(m_pc);
        end

        i_Stall = st; i_Redirect = rd; i_Redirect_Target = tgt; i_IMem_Ack = ak;
        i_IMem_Data = ak ? mem_word(e_addr) : 32'hDEAD_BEEF;
        @(negedge i_Clk);
        chk("req", {31'h0, o_IMem_Req}, {31'h0, e_req});
        if (e_req) chk("addr", o_IMem_Addr, e_addr);
        if (kchk) chk("addr_k", o_IMem_Addr, kaddr);
        chk("valid", {31'h0, o_Valid}, {31'h0, e_valid});
        chk("pc", o_PC, e_pc);
        chk("instr", o_Instruction, e_instr);
        chk("misal", {31'h0, o_Misaligned}, {31'h0, e_mis});

        if (rd) begin
            if (e_req && !ak) begin
                if (!m_drop) m_daddr = e_addr;
                m_drop = 1'b1;
            end else begin
                m_drop = 1'b0;
            end
            m_held = 1'b0;
            m_pc   = tgt_eff;
        end else if (m_held) begin
            if (!st) begin
                m_held = 1'b0;
                m_pc   = m_pc + 32'd4;
            end
        end else if (m_drop) begin
            if (ak) m_drop = 1'b0;
        end else if (ak) begin
            if (st) begin
                m_held = 1'b1; m_hpc = m_pc + 32'd4; m_hinstr = mem_word(m_pc);
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge i_Clk); #1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        model_reset();
        @(posedge i_Clk); #1;
        do_reset();

        // Zero-wait memory: one instruction per cycle.
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0000);
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0004);
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0008);
        // Two wait states.
        cycle(0, 0, 32'h0, 0, 1, 32'h0000_000C);
        cycle(0, 0, 32'h0, 0, 1, 32'h0000_000C);
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_000C);
        // Ack while stalled at 0x10, held three cycles.
        cycle(1, 0, 32'h0, 1, 1, 32'h0000_0010);
        cycle(1, 0, 32'h0, 0, 0, 32'h0);
        cycle(1, 0, 32'h0, 0, 0, 32'h0);
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0014);
        cycle(0, 0, 32'h0, 1, 0, 32'h0);
        cycle(0, 0, 32'h0, 1, 0, 32'h0);
        // Redirect to 0x40 while 0x20 is pending.
        cycle(0, 1, 32'h0000_0040, 0, 1, 32'h0000_0020);
        cycle(0, 0, 32'h0, 0, 1, 32'h0000_0020);
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0020);
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0040);
        // Redirect and stall together.
        cycle(1, 1, 32'h0000_0040, 1, 0, 32'h0);
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0040);
        // Misaligned target.
        cycle(0, 1, 32'h0000_0042, 1, 0, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0180);
`else
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0040);
`endif
        // PC wraps at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0);
        cycle(0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0000);
        // Reset while a request is outstanding.
        cycle(0, 0, 32'h0, 0, 0, 32'h0);
        do_reset();
        cycle(0, 0, 32'h0, 1, 1, 32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom, ($urandom % 3) != 0,
                  1'b0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
